instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
Upstream program-load stage for the 8-bit CPU. It receives a program image as a byte stream over a valid/ready handshake and writes it into its own instruction store. It serves the CPU's combinational fetch port (pc in, instr out) and holds the CPU core in reset (cpu_rst) until a complete, valid image has been loaded. A load_req pulse re-enters load mode at run time.

Parameters:
DEPTH, 16, number of instruction store entries (1..255)
FILL, 8'hC0, instruction returned for fetches at or beyond the loaded length (JMP 0)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
load_req  input  1  single-cycle request to reload; honoured only in RUN
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
fetch_addr  input  8  CPU program counter
fetch_instr  output  8  instruction at fetch_addr (combinational)
cpu_rst  output  1  registered reset to the CPU core, active-high
done  output  1  image loaded, CPU running
err  output  1  sticky error: bad length, or bad checksum when enabled
byte_count  output  8  image bytes written in the current load

Behaviour:
- Clock and reset: clk is the clock; rst is asynchronous and active-high.
- Reset values: state=IDLE, cpu_rst=1, done=0, err=0, byte_count=0, len_q=0, sum=0.
- Instruction store contents are not reset.
- Transfer rule: a byte is taken on any clk edge where in_valid && in_ready.
- in_ready=1 in IDLE, LOAD and CHECK; in_ready=0 in RUN.
- in_data only needs to be stable while in_valid=1.
- IDLE, length byte taken:
  - value 0 or value > DEPTH: err<=1, stay in IDLE.
  - otherwise: len_q<=value, err<=0, byte_count<=0, sum<=0, go to LOAD.
- LOAD, byte taken: mem[byte_count]<=in_data, sum<=sum+in_data (mod 256), byte_count<=byte_count+1.
  - When byte_count==len_q-1 on a taken byte: go to CHECK if the feature is enabled, else RUN.
- RUN: cpu_rst<=0 and done<=1, both registered. They change on the edge that enters RUN, so the CPU starts fetching at pc=0 on the next cycle.
- RUN with load_req=1: go to IDLE, cpu_rst<=1, done<=0, err<=0, len_q<=0.
- load_req in any other state is ignored.
- cpu_rst=1 in every state except RUN.
- Fetch: fetch_instr = (fetch_addr < len_q) ? mem[fetch_addr] : FILL.
  - Zero latency; the comparison is 8-bit unsigned.
  - While len_q=0 (during a load), every fetch returns FILL.
- Entries beyond a shorter new image keep old data but are masked to FILL by len_q.
- Stalls: in_valid low mid-load simply pauses the load. There is no timeout.
- rst during LOAD or CHECK aborts the image. len_q=0 after reset, so no partial image is ever executed.

Optional Feature:
Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - After the last image byte the state is CHECK.
  - The next taken byte is compared with sum (8-bit two's-complement sum of the image bytes, length byte excluded).
  - Match: go to RUN.
  - Mismatch: err<=1, len_q<=0, go to IDLE, cpu_rst stays 1.
- Undefined: CHECK state and sum register are absent; LOAD goes directly to RUN.

Test Plan:
1. Reset, then stream 03,10,25,C2 (no checksum build) -> in_ready high throughout; byte_count 1,2,3; cpu_rst falls and done rises on the edge after C2; fetch 0/1/2 = 10/25/C2; fetch 3 = C0.
2. Length byte 00, then 11 (DEPTH=16) -> err=1 after each, state stays IDLE, cpu_rst=1; a following 02 clears err.
3. Pulse in_valid low for 5 cycles between image bytes -> no write, byte_count frozen, load completes correctly afterwards.
4. In RUN, pulse load_req, then load 01,40 -> cpu_rst=1 and done=0 the cycle after load_req, in_ready=1; after reload fetch 0 = 40 and fetch 1 = C0 (old data masked).
5. Assert rst mid-LOAD after 2 of 4 bytes -> cpu_rst=1, done=0, byte_count=0; all fetches return C0.
6. With INSTR_LOADER_CHECKSUM_EN: 02,10,20,30 -> RUN. Then, after load_req: 02,10,20,31 -> err=1, IDLE, cpu_rst=1, fetch 0 = C0.

Source files
------------

// File: rtl/instr_loader_if.sv
// Program-image byte stream between the upstream source and instr_loader.
// The master drives valid/data and the slave returns ready.
interface instr_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/instr_loader.sv
// Program loader for the 8-bit CPU: streams an image into a local store, serves fetches,
// and holds cpu_rst until the image is in. Define INSTR_LOADER_CHECKSUM_EN for a trailing checksum byte.
module instr_loader #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  FILL  = 8'hC0
) (
  input  logic               clk,
  input  logic               rst,
  instr_loader_if.slave      s,
  input  logic               load_req,
  input  logic [7:0]         fetch_addr,
  output logic [7:0]         fetch_instr,
  output logic               cpu_rst,
  output logic               done,
  output logic               err,
  output logic [7:0]         byte_count
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  DEPTH8 = 8'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef INSTR_LOADER_CHECKSUM_EN
    CHECK,
`endif
    RUN
  } state_t;

  state_t     state;
  logic [7:0] len_q;
  logic [7:0] mem [2**AW];
  logic       take;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign s.in_ready = (state != RUN);
  assign take       = s.in_valid && s.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_count <= '0;
      len_q      <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            if (s.in_data == 8'd0 || s.in_data > DEPTH8) begin
              err <= 1'b1;
            end else begin
              len_q      <= s.in_data;
              err        <= 1'b0;
              byte_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
              sum        <= '0;
`endif
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (take) begin
            byte_count <= byte_count + 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum        <= sum + s.in_data;
            if (byte_count == len_q - 8'd1) state <= CHECK;
`else
            if (byte_count == len_q - 8'd1) begin
              state   <= RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end
`endif
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK: begin
          if (take) begin
            if (s.in_data == sum) begin
              state   <= RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              // Drop the image so a bad load can never be fetched from.
              err   <= 1'b1;
              len_q <= '0;
              state <= IDLE;
            end
          end
        end
`endif
        RUN: begin
          if (load_req) begin
            state   <= IDLE;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            len_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store is deliberately not reset; len_q masks anything not from the current image.
  always_ff @(posedge clk) begin
    if (state == LOAD && take) mem[byte_count[AW-1:0]] <= s.in_data;
  end

  always_comb begin
    fetch_instr = FILL;
    if (fetch_addr < len_q) fetch_instr = mem[fetch_addr[AW-1:0]];
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: vector table for the main load/reload flow, plus
// hand-written sequences for mid-load reset and a full-depth image.
module tb_instr_loader;
  logic       clk;
  logic       rst;
  logic       load_req;
  logic [7:0] fetch_addr;
  logic [7:0] fetch_instr;
  logic       cpu_rst;
  logic       done;
  logic       err;
  logic [7:0] byte_count;

  instr_loader_if bus ();

  instr_loader #(.DEPTH(16), .FILL(8'hC0)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .load_req    (load_req),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .err         (err),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       lr;
    logic [7:0] a;
    logic       rdy;
    logic       crst;
    logic       dn;
    logic       er;
    logic [7:0] bc;
    logic [7:0] ins;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic v, input logic [7:0] d, input logic lr, input logic [7:0] a,
                     input logic rdy, input logic crst, input logic dn, input logic er,
                     input logic [7:0] bc, input logic [7:0] ins);
    vec_t t;
    t.v = v; t.d = d; t.lr = lr; t.a = a;
    t.rdy = rdy; t.crst = crst; t.dn = dn; t.er = er; t.bc = bc; t.ins = ins;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic step(input logic v, input logic [7:0] d, input logic lr, input logic [7:0] a);
    bus.in_valid = v;
    bus.in_data  = d;
    load_req     = lr;
    fetch_addr   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic crst, input logic dn,
                         input logic er, input logic [7:0] bc);
    chk({tag, " in_ready"},   {7'd0, bus.in_ready}, {7'd0, rdy});
    chk({tag, " cpu_rst"},    {7'd0, cpu_rst},      {7'd0, crst});
    chk({tag, " done"},       {7'd0, done},         {7'd0, dn});
    chk({tag, " err"},        {7'd0, err},          {7'd0, er});
    chk({tag, " byte_count"}, byte_count,           bc);
  endtask

  initial begin
    logic [7:0] img [16];
    logic [7:0] s;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    load_req     = 1'b0;
    fetch_addr   = 8'h00;
    #2;
    chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("reset fetch0", fetch_instr, 8'hC0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef INSTR_LOADER_CHECKSUM_EN
    //   v  data   lr  addr   rdy crst dn er  bc     instr
    add(1, 8'h02, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'd1, 8'h10);
    add(1, 8'h20, 0, 8'h01, 1, 1, 0, 0, 8'd2, 8'h20);
    add(1, 8'h30, 0, 8'h00, 0, 0, 1, 0, 8'd2, 8'h10);
    add(0, 8'h00, 1, 8'h00, 1, 1, 0, 0, 8'd2, 8'hC0);
    add(1, 8'h02, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'd1, 8'h10);
    add(1, 8'h20, 0, 8'h01, 1, 1, 0, 0, 8'd2, 8'h20);
    add(1, 8'h31, 0, 8'h00, 1, 1, 0, 1, 8'd2, 8'hC0);
    add(1, 8'h01, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'h07, 0, 8'hFF, 1, 1, 0, 0, 8'd1, 8'hC0);
    add(1, 8'h07, 0, 8'h00, 0, 0, 1, 0, 8'd1, 8'h07);
`else
    add(1, 8'h03, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'd1, 8'h10);
    add(1, 8'h25, 0, 8'h01, 1, 1, 0, 0, 8'd2, 8'h25);
    add(1, 8'hC2, 0, 8'h02, 0, 0, 1, 0, 8'd3, 8'hC2);
    add(0, 8'h00, 0, 8'h03, 0, 0, 1, 0, 8'd3, 8'hC0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'd3, 8'h10);
    add(0, 8'h00, 1, 8'h00, 1, 1, 0, 0, 8'd3, 8'hC0);
    add(1, 8'h00, 0, 8'h00, 1, 1, 0, 1, 8'd3, 8'hC0);
    add(1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'd3, 8'hC0);
    add(1, 8'h02, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'hAA, 0, 8'h00, 1, 1, 0, 0, 8'd1, 8'hAA);
    for (int i = 0; i < 5; i++)
      add(0, 8'h55, 0, 8'h01, 1, 1, 0, 0, 8'd1, 8'h25);
    add(1, 8'hBB, 0, 8'h01, 0, 0, 1, 0, 8'd2, 8'hBB);
    add(0, 8'h00, 0, 8'h02, 0, 0, 1, 0, 8'd2, 8'hC0);
    add(0, 8'h00, 1, 8'h00, 1, 1, 0, 0, 8'd2, 8'hC0);
    add(1, 8'h01, 0, 8'hFF, 1, 1, 0, 0, 8'd0, 8'hC0);
    add(1, 8'h40, 0, 8'h00, 0, 0, 1, 0, 8'd1, 8'h40);
    add(1, 8'h05, 0, 8'h01, 0, 0, 1, 0, 8'd1, 8'hC0);
    add(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'd1, 8'h40);
`endif

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].v, tbl[i].d, tbl[i].lr, tbl[i].a);
      chk_all(tag, tbl[i].rdy, tbl[i].crst, tbl[i].dn, tbl[i].er, tbl[i].bc);
      chk({tag, " fetch_instr"}, fetch_instr, tbl[i].ins);
    end

    // Reload request, then reset partway through a 4-byte image.
    step(0, 8'h00, 1, 8'h00);
    step(1, 8'h04, 0, 8'h00);
    step(1, 8'h01, 0, 8'h00);
    step(1, 8'h02, 0, 8'h00);
    chk("midload byte_count", byte_count, 8'd2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_all("rst_midload", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int a = 0; a < 4; a++) begin
      fetch_addr = 8'(a);
      #1;
      chk($sformatf("rst_midload fetch%0d", a), fetch_instr, 8'hC0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-depth image: length equal to DEPTH is the largest accepted.
    s = 8'h00;
    step(1, 8'h10, 0, 8'hFF);
    chk_all("depth_len", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'(3 * i + 1);
      s = s + img[i];
      step(1, img[i], 0, 8'hFF);
      chk($sformatf("depth bc%0d", i), byte_count, 8'(i + 1));
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("depth check cpu_rst", {7'd0, cpu_rst}, 8'd1);
    step(1, s, 0, 8'hFF);
`endif
    step(0, 8'h00, 0, 8'h10);
    chk_all("depth_run", 1'b0, 1'b0, 1'b1, 1'b0, 8'd16);
    chk("depth fetch16", fetch_instr, 8'hC0);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 8'(a);
      #1;
      chk($sformatf("depth fetch%0d", a), fetch_instr, img[a]);
    end
    fetch_addr = 8'hFF;
    #1;
    chk("depth fetchFF", fetch_instr, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
